// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 16x-oversampling UART receiver.
//
// Receive-side partner of the UART transmitter. It watches the asynchronous
// serial line, finds each start bit and samples the middle of every data bit
// using the shared baud tick. The completed character is presented on dout
// together with a one-clock rx_done_tick strobe, which is the write request
// into the RX FIFO.
//
// Frame: 1 start bit, DBIT data bits LSB first, no parity, SB_TICK ticks of
// stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   s_tick       oversampling enable, one clk wide, 16 per bit period
//   rx           serial line, asynchronous to clk, idles high
//   dout         last received character, held until the next frame ends
//   rx_done_tick one-clk pulse: dout and frame_err are newly valid
//   frame_err    the stop sample of the last frame was 0
//   busy         high while the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DBIT    = 8,   // data bits per frame, 5..8
    parameter int SB_TICK = 16,  // ticks spent in the stop state, 16..32
    parameter int MIDBIT  = 8    // ticks from the start edge to mid start bit
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Terminal counts, sized to the counters they are compared against.
    // A 5-bit tick counter reaches 31, enough for the longest stop period.
    localparam logic [4:0] MID_LAST  = 5'(MIDBIT - 1);
    localparam logic [4:0] BIT_TICKS = 5'd15;
    localparam logic [4:0] SB_LAST   = 5'(SB_TICK - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

    state_t          state, state_next;
    logic [4:0]      tick_cnt, tick_next;
    logic [2:0]      bit_cnt, bit_next;
    logic [DBIT-1:0] sreg, sreg_next;
    logic [DBIT-1:0] dout_next;
    logic            done_next;
    logic            ferr_next;

    // -----------------------------------------------------------------------
    // Input synchronizer. It runs on every clk, not only on ticks, so the
    // line is settled long before the FSM looks at it. Both flops reset to
    // the idle level so leaving reset never looks like a start edge.
    // -----------------------------------------------------------------------
    logic rx_m;
    logic rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // -----------------------------------------------------------------------
    // State and datapath registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= 5'd0;
            bit_cnt      <= 3'd0;
            sreg         <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_next;
            tick_cnt     <= tick_next;
            bit_cnt      <= bit_next;
            sreg         <= sreg_next;
            dout         <= dout_next;
            rx_done_tick <= done_next;
            frame_err    <= ferr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Everything holds unless s_tick is high. The done
    // strobe defaults low every clk, so it stays a single clk wide even if
    // s_tick is tied high.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        sreg_next  = sreg;
        dout_next  = dout;
        ferr_next  = frame_err;
        done_next  = 1'b0;

        if (s_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_next = START;
                        tick_next  = 5'd0;
                    end
                end

                START: begin
                    // Re-check the line at mid start bit. A line that is
                    // high again was a glitch, so drop back to idle quietly.
                    if (tick_cnt == MID_LAST) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            tick_next  = 5'd0;
                            bit_next   = 3'd0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        tick_next = tick_cnt + 5'd1;
                    end
                end

                DATA: begin
                    // One full bit period after mid start lands mid data
                    // bit. Shifting in at the MSB leaves the first bit
                    // received in sreg[0] once all DBIT bits are in.
                    if (tick_cnt == BIT_TICKS) begin
                        sreg_next = {rx_s, sreg[DBIT-1:1]};
                        tick_next = 5'd0;
                        if (bit_cnt == BIT_LAST) begin
                            state_next = STOP;
                        end else begin
                            bit_next = bit_cnt + 3'd1;
                        end
                    end else begin
                        tick_next = tick_cnt + 5'd1;
                    end
                end

                STOP: begin
                    // A low stop sample is flagged, but the character is
                    // still delivered and strobed.
                    if (tick_cnt == SB_LAST) begin
                        dout_next  = sreg;
                        ferr_next  = ~rx_s;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        tick_next = tick_cnt + 5'd1;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
//
// Two receivers share clock, reset and baud tick: dut (DBIT=8, SB_TICK=16)
// and dut7 (DBIT=7, SB_TICK=32), each with its own serial line. The tick is
// either one clk in sixteen or tied high. A monitor logs every strobe with
// its payload and the tick index that produced it. Expected characters,
// error flags and strobe timing come from the frame rules:
// mid-start sample 9 ticks after the start edge, one sample every 16 ticks,
// strobe SB_TICK ticks after the last data sample.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic       rx7 = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick, frame_err, busy;
    logic [6:0] dout7;
    logic       rx_done_tick7, frame_err7, busy7;

    uart_rx dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx),
        .dout(dout), .rx_done_tick(rx_done_tick),
        .frame_err(frame_err), .busy(busy)
    );

    uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx7),
        .dout(dout7), .rx_done_tick(rx_done_tick7),
        .frame_err(frame_err7), .busy(busy7)
    );

    int errors = 0;
    int checks = 0;

    bit tied = 1'b0;
    int ph = 0;
    int tick_idx = 0;

    logic [8:0] obs_q[$];    // {frame_err, dout}
    int         obs_t[$];
    logic [7:0] obs7_q[$];   // {frame_err7, dout7}
    int         obs7_t[$];
    logic       prev_done = 1'b0;
    logic       prev_done7 = 1'b0;
    int         wide_cnt = 0;

    always #5 clk = ~clk;

    // Monitor first (it sees what the last rising edge produced, tagged with
    // the tick that edge consumed), then present the next tick.
    always @(negedge clk) begin
        if (rx_done_tick) begin
            obs_q.push_back({frame_err, dout});
            obs_t.push_back(tick_idx);
        end
        if (rx_done_tick7) begin
            obs7_q.push_back({frame_err7, dout7});
            obs7_t.push_back(tick_idx);
        end
        if ((rx_done_tick && prev_done) || (rx_done_tick7 && prev_done7))
            wide_cnt++;
        prev_done  = rx_done_tick;
        prev_done7 = rx_done_tick7;

        s_tick = tied ? 1'b1 : (ph == 0);
        ph = (ph + 1) % 16;
        if (s_tick) tick_idx++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Wait for n consumed ticks, then step just past the edge.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!s_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive(input bit use7, input logic v);
        if (use7) rx7 = v;
        else rx = v;
    endtask

    // One frame, bit-aligned to the tick. t0 is the tick after which the
    // start edge is driven.
    task automatic send_frame(input logic [7:0] d, input int nbits,
                              input logic stop, input int sb,
                              input bit use7, output int t0);
        drive(use7, 1'b0);
        t0 = tick_idx;
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            drive(use7, d[i]);
            wait_ticks(16);
        end
        drive(use7, stop);
        wait_ticks(sb);
        drive(use7, 1'b1);
    endtask

    task automatic test_reset();
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
        checks++; if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", rx_done_tick); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (dout7 !== 7'h00) begin errors++; $display("FAIL reset_dout7: got %h want 00", dout7); end
        reset = 1'b0;
        wait_ticks(3);
        checks++; if (busy !== 1'b0 || busy7 !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy=%b busy7=%b want 0 0", busy, busy7); end
    endtask

    task automatic test_basic();
        int t0;
        tied = 1'b0;
        obs_q.delete(); obs_t.delete();
        send_frame(8'hA5, 8, 1'b1, 16, 1'b0, t0);
        wait_ticks(1);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL basic_count: got %0d strobes want 1", obs_q.size());
        end else begin
            checks++; if (obs_q[0] !== {1'b0, 8'hA5}) begin errors++; $display("FAIL basic_data: got %h want 0a5", obs_q[0]); end
            checks++; if (obs_t[0] !== t0 + 9 + 16 * 8 + 16) begin errors++; $display("FAIL basic_time: got tick %0d want %0d", obs_t[0], t0 + 153); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
    endtask

    task automatic test_glitch();
        tied = 1'b0;
        obs_q.delete(); obs_t.delete();
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
        wait_ticks(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_idle: got %b want 0", busy); end
        wait_ticks(16);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_strobe: got %0d strobes want 0", obs_q.size()); end
        checks++; if ({frame_err, dout} !== {1'b0, 8'hA5}) begin errors++; $display("FAIL glitch_hold: got %h want 0a5", {frame_err, dout}); end
    endtask

    task automatic test_frame_err();
        int t0;
        tied = 1'b0;
        obs_q.delete(); obs_t.delete();
        send_frame(8'h3C, 8, 1'b0, 16, 1'b0, t0);
        wait_ticks(24);
        send_frame(8'h81, 8, 1'b1, 16, 1'b0, t0);
        wait_ticks(1);
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL ferr_count: got %0d strobes want 2", obs_q.size());
        end else begin
            checks++; if (obs_q[0] !== {1'b1, 8'h3C}) begin errors++; $display("FAIL ferr_bad: got %h want 13c", obs_q[0]); end
            checks++; if (obs_q[1] !== {1'b0, 8'h81}) begin errors++; $display("FAIL ferr_clean: got %h want 081", obs_q[1]); end
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        tied = 1'b1;
        wide_cnt = 0;
        obs_q.delete(); obs_t.delete();
        send_frame(8'h00, 8, 1'b1, 16, 1'b0, t0);
        send_frame(8'hFF, 8, 1'b1, 16, 1'b0, t0);
        wait_ticks(4);
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d strobes want 2", obs_q.size());
        end else begin
            checks++; if (obs_q[0] !== {1'b0, 8'h00}) begin errors++; $display("FAIL b2b_first: got %h want 000", obs_q[0]); end
            checks++; if (obs_q[1] !== {1'b0, 8'hFF}) begin errors++; $display("FAIL b2b_second: got %h want 0ff", obs_q[1]); end
            // Frames are 10 bits of 16 ticks each with no gap between them.
            checks++; if (obs_t[1] - obs_t[0] !== 160) begin errors++; $display("FAIL b2b_spacing: got %0d want 160", obs_t[1] - obs_t[0]); end
        end
        checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL b2b_width: got %0d wide strobes want 0", wide_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        logic [7:0] d;
        d = 8'h5A;
        tied = 1'b0;
        obs_q.delete(); obs_t.delete();
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
        rx = d[4];
        wait_ticks(8);
        reset = 1'b1;
        #1;
        checks++; if ({dout, rx_done_tick, frame_err, busy} !== 11'd0) begin errors++; $display("FAIL rst_mid_outputs: got %h want 000", {dout, rx_done_tick, frame_err, busy}); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({dout, frame_err, busy} !== 10'd0) begin errors++; $display("FAIL rst_mid_held: got %h want 000", {dout, frame_err, busy}); end
        reset = 1'b0;
        rx = 1'b1;
        wait_ticks(24);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rst_mid_abort: got %0d strobes want 0", obs_q.size()); end
        send_frame(8'hC3, 8, 1'b1, 16, 1'b0, t0);
        wait_ticks(1);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL rst_mid_count: got %0d strobes want 1", obs_q.size());
        end else begin
            checks++; if (obs_q[0] !== {1'b0, 8'hC3}) begin errors++; $display("FAIL rst_mid_data: got %h want 0c3", obs_q[0]); end
        end
    endtask

    task automatic test_dbit7();
        int t0;
        tied = 1'b0;
        obs7_q.delete(); obs7_t.delete();
        send_frame(8'h55, 7, 1'b1, 32, 1'b1, t0);
        wait_ticks(1);
        checks++;
        if (obs7_q.size() != 1) begin
            errors++; $display("FAIL dbit7_count: got %0d strobes want 1", obs7_q.size());
        end else begin
            checks++; if (obs7_q[0] !== {1'b0, 7'h55}) begin errors++; $display("FAIL dbit7_data: got %h want 55", obs7_q[0]); end
            // Last data sample at t0+9+16*7; strobe 32 ticks later.
            checks++; if (obs7_t[0] !== t0 + 9 + 16 * 7 + 32) begin errors++; $display("FAIL dbit7_time: got tick %0d want %0d", obs7_t[0], t0 + 153); end
        end
        checks++; if (busy7 !== 1'b0) begin errors++; $display("FAIL dbit7_busy: got %b want 0", busy7); end
    endtask

    task automatic test_break();
        int t0;
        tied = 1'b1;
        obs_q.delete(); obs_t.delete();
        rx = 1'b0;
        t0 = tick_idx;
        wait_ticks(400);
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL break_count: got %0d strobes want 2", obs_q.size());
        end else begin
            checks++; if (obs_q[0] !== {1'b1, 8'h00} || obs_q[1] !== {1'b1, 8'h00}) begin errors++; $display("FAIL break_data: got %h %h want 100 100", obs_q[0], obs_q[1]); end
            // Ticks every clk: 2 ticks of synchronizer delay, then 1 idle
            // tick + 8 start + 128 data + 16 stop per frame.
            checks++; if (obs_t[0] - t0 !== 2 + 153) begin errors++; $display("FAIL break_first: got %0d want 155", obs_t[0] - t0); end
            checks++; if (obs_t[1] - obs_t[0] !== 153) begin errors++; $display("FAIL break_period: got %0d want 153", obs_t[1] - obs_t[0]); end
        end
        rx = 1'b1;
        wait_ticks(200);
    endtask

    task automatic test_random();
        int t0;
        int gap;
        logic [7:0] d;
        logic stop;
        logic [8:0] exp_q[$];
        tied = 1'b1;
        obs_q.delete(); obs_t.delete();
        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom);
            stop = ($urandom_range(3) != 0);
            send_frame(d, 8, stop, 16, 1'b0, t0);
            exp_q.push_back({~stop, d});
            // A low stop bit needs idle time so the line is seen high again.
            gap = stop ? int'($urandom_range(6)) : 12 + int'($urandom_range(8));
            wait_ticks(gap);
        end
        wait_ticks(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_frame%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_dbit7();
        test_break();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampling UART receiver; the receive-side counterpart of the team's UART transmitter.
- Consumes the shared baud-rate tick (s_tick, 16 pulses per bit period) and the asynchronous serial line rx.
- Delivers each received character on dout with a one-clock rx_done_tick strobe; the strobe is the write request into the RX FIFO.
- Frame format: 1 start bit, DBIT data bits LSB first, no parity, stop period of SB_TICK ticks.

Parameters:
- DBIT, 8, data bits per frame; legal range 5..8.
- SB_TICK, 16, ticks spent in stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2); legal range 16..32.
- MIDBIT, 8, tick count to the centre of the start bit.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_tick  input  1  oversampling enable, one clk wide, 16 per bit period.
- rx  input  1  serial line, asynchronous to clk, idle high.
- dout  output  DBIT  last received character, held until the next completed frame.
- rx_done_tick  output  1  one-clk pulse: dout and frame_err are newly valid.
- frame_err  output  1  stop sample of the last frame was 0; updated together with dout.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous) values:
  - state IDLE; tick counter 0; bit counter 0; shift register 0.
  - dout 0, rx_done_tick 0, frame_err 0.
  - Both synchronizer flops 1.
- Reset asserted mid-frame aborts the frame. No rx_done_tick is issued and dout is unchanged from its reset value of 0.
- Input path:
  - rx passes through a 2-flop synchronizer clocked every clk, not only on s_tick.
  - All decisions use the second flop, rx_s. Line-to-decision latency is 2 clk.
- State machine: the FSM advances only on clk edges where s_tick = 1. Counters hold when s_tick = 0.
- IDLE:
  - If rx_s = 0: go to START, tick counter <= 0.
  - Otherwise stay in IDLE.
- START:
  - If tick counter = MIDBIT-1 and rx_s = 0: go to DATA, tick counter <= 0, bit counter <= 0.
  - If tick counter = MIDBIT-1 and rx_s = 1: false start (glitch); return to IDLE with no output activity.
  - Otherwise tick counter += 1.
- DATA:
  - If tick counter = 15: shift right, inserting rx_s at the MSB (sreg <= {rx_s, sreg[DBIT-1:1]}), tick counter <= 0.
  - If bit counter = DBIT-1 on that shift, go to STOP; otherwise bit counter += 1.
  - Otherwise tick counter += 1.
  - After DBIT shifts, sreg[0] holds the first bit received.
- STOP:
  - If tick counter = SB_TICK-1: dout <= sreg, frame_err <= ~rx_s, rx_done_tick <= 1, return to IDLE.
  - Otherwise tick counter += 1.
  - A framing error still delivers the data and still strobes.
- rx_done_tick:
  - Defaults to 0 on every clk, so it is exactly one clk wide even when s_tick is continuously high.
  - dout and frame_err change only in that same cycle.
- Back-to-back frames: a start edge arriving on the first tick after the return to IDLE is accepted. No dead time beyond one tick.
- rx held low permanently (break):
  - Each frame completes with frame_err = 1 and dout = 0.
  - The receiver then re-enters START from IDLE on the next tick.
- Tick counter width is 5 bits, which covers SB_TICK-1 up to 31. Bit counter width is 3 bits.
- busy = (state != IDLE), combinational from the state register.

Test Plan:
- Frame 0xA5, 1 stop bit, s_tick every 16 clk, DBIT=8 -> exactly one rx_done_tick; dout = 0xA5; frame_err = 0; busy low 1 tick after the strobe.
- rx low for 4 ticks then high (glitch) -> FSM returns to IDLE at START count 7; no rx_done_tick; dout unchanged.
- Frame 0x3C with stop bit driven 0 -> rx_done_tick with dout = 0x3C and frame_err = 1. Next clean frame 0x81 -> dout = 0x81, frame_err = 0.
- Back-to-back 0x00 then 0xFF, no idle gap, s_tick tied high -> two strobes, each 1 clk wide; dout = 0x00 then 0xFF.
- Reset pulse at data bit 4 of 0x5A, then a full frame 0xC3 -> no strobe for the aborted frame; all outputs 0 during reset; next strobe shows dout = 0xC3.
- DBIT=7, SB_TICK=32, frame 0x55 -> dout = 7'h55; strobe occurs 32 ticks after the last data sample.
